// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and step count shared by the
// multiply/divide unit and its per-cycle datapath.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [4:0] STEP_LAST = 5'd31;

    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic        sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply step or one restoring divide step
// on unsigned magnitudes; purely combinational.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        i_div,
    input  logic [31:0] i_acc,
    input  logic [31:0] i_low,
    input  logic [31:0] i_opnd,
    output logic [31:0] o_acc,
    output logic [31:0] o_low
);

    logic [32:0] w_sum;
    logic [32:0] w_sh;
    logic [31:0] w_diff;
    logic        w_ge;

    // multiply: acc:low is the partial product, low[0] is the next multiplier bit
    assign w_sum  = {1'b0, i_acc} + (i_low[0] ? {1'b0, i_opnd} : 33'd0);

    // divide: acc is the partial remainder, low shifts dividend out, quotient in
    assign w_sh   = {i_acc, i_low[31]};
    assign w_ge   = (w_sh >= {1'b0, i_opnd});
    assign w_diff = w_sh[31:0] - i_opnd;

    always_comb begin
        o_acc = w_sum[32:1];
        o_low = {w_sum[0], i_low[31:1]};
        if (i_div) begin
            o_acc = w_ge ? w_diff : w_sh[31:0];
            o_low = {i_low[30:0], w_ge};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
// Define MULDIV_FAST_MULT_EN for single-cycle multiplies.
module mul_div_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_low;
    logic [31:0] r_opnd;
    logic        r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_step_acc;
    logic [31:0] w_step_low;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_a_mag  = mag32(a, w_signed);
    assign w_b_mag  = mag32(b, w_signed);

    muldiv_step u_step (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_low  (r_low),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc),
        .o_low  (w_step_low)
    );

    assign w_prod     = {w_step_acc, w_step_low};
    assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
    assign w_rem      = r_neg_r ? (32'd0 - w_step_acc) : w_step_acc;
    assign w_quo      = r_div0 ? 32'hFFFF_FFFF
                      : (r_neg_q ? (32'd0 - w_step_low) : w_step_low);

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] w_fast;
    logic        w_sa;
    logic        w_sb;

    assign w_sa   = w_signed & a[31];
    assign w_sb   = w_signed & b[31];
    assign w_fast = {{32{w_sa}}, a} * {{32{w_sb}}, b};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_acc   <= 32'd0;
            r_low   <= 32'd0;
            r_opnd  <= 32'd0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wd;
                    if (lo_we) r_lo <= wd;
                    if (start) begin
                        r_div   <= op[1];
                        r_neg_q <= w_signed & (a[31] ^ b[31]);
                        r_neg_r <= w_signed & a[31];
                        r_div0  <= op[1] && (b == 32'd0);
                        r_acc   <= 32'd0;
                        r_low   <= op[1] ? w_a_mag : w_b_mag;
                        r_opnd  <= op[1] ? w_b_mag : w_a_mag;
`ifdef MULDIV_FAST_MULT_EN
                        if (!op[1]) begin
                            r_hi    <= w_fast[63:32];
                            r_lo    <= w_fast[31:0];
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= STEP_LAST;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
`else
                        r_cnt   <= STEP_LAST;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    r_acc <= w_step_acc;
                    r_low <= w_step_low;
                    if (r_cnt == 5'd0) begin
                        r_hi    <= r_div ? w_rem : w_prod_fix[63:32];
                        r_lo    <= r_div ? w_quo : w_prod_fix[31:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    if (hi_we) r_hi <= wd;
                    if (lo_we) r_lo <= wd;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have no parameters; data width fixed at 32.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request an operation; sampled only in IDLE.
REQ-005 op  in  2  operation: MULT, MULTU, DIV, DIVU.
REQ-006 a  in  32  operand A / dividend, driven from register-file read port 1.
REQ-007 b  in  32  operand B / divisor, driven from register-file read port 2.
REQ-008 hi_we, lo_we  in  1 each  MTHI/MTLO write enables.
REQ-009 wd  in  32  MTHI/MTLO write data.
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-cycle pulse when hi/lo hold a new result.
REQ-012 hi, lo  out  32 each  result registers, read by MFHI/MFLO toward the register-file write port.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE->RUN SHALL occur on an edge with start=1 (accept edge): a, b and op latched; step counter loaded with 31.
REQ-015 RUN SHALL perform one shift-add (multiply) or restoring (divide) step per edge, on unsigned magnitudes; at count 0 go to DONE and load hi/lo, else decrement.
REQ-016 Result SHALL appear and done=1 exactly 32 edges after the accept edge; DONE->IDLE on the next edge unconditionally.
REQ-017 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-018 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
REQ-019 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
REQ-020 Signed ops: negate operands to magnitudes at accept, fix result signs at the DONE load.
REQ-021 Divide by zero: lo=32'hFFFFFFFF, hi=dividend, full latency, no other indication.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-023 start while in RUN or DONE SHALL be ignored, not queued.
REQ-024 Operand or op changes after the accept edge SHALL have no effect.
REQ-025 hi_we/lo_we SHALL update hi/lo from wd in IDLE and DONE, and SHALL be ignored in RUN.
REQ-026 Simultaneous start and hi_we/lo_we in IDLE: the write is applied; the later result overwrites it.
REQ-027 hi/lo SHALL change only on hi_we/lo_we writes or the DONE load.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0.
REQ-029 Reset during RUN SHALL abort the operation with no result or done pulse; start is accepted on the first edge after deassertion.

Configuration
REQ-030 Macro MULDIV_FAST_MULT_EN defined: MULT/MULTU SHALL compute in one cycle (IDLE->DONE at the accept edge, done=1 one edge after accept, busy never asserted); divide is unchanged.
REQ-031 Macro undefined: every operation SHALL use the 32-step iterative path of REQ-014 to REQ-016.

Structure
REQ-032 Shared package muldiv_pkg SHALL hold the op encodings (MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11), the state encoding and the step-count constant (31).
REQ-033 Sub-module muldiv_step SHALL hold the per-cycle shift-add/restore datapath; the FSM, counter, sign handling and hi/lo registers stay in mul_div_unit.

Verification
REQ-034 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; done 32 edges after accept (1 edge with MULDIV_FAST_MULT_EN).
REQ-035 MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-036 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV a=5, b=0 -> lo=32'hFFFFFFFF, hi=5; DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-037 Second start and hi_we=1 (wd=32'h1234) during RUN -> both ignored; first result intact; exactly one done pulse.
REQ-038 hi_we=1, wd=32'hCAFE in IDLE -> hi=32'hCAFE next edge, lo unchanged.
REQ-039 Assert reset 10 edges into a DIV -> busy=0, hi=lo=0 immediately; no done; a new MULTU 3*4 after release -> lo=12, hi=0.
